// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and its neighbours.
//   BOOT_PC_DEFAULT  address of the first fetch after reset
//   FS_TO_DS_BUS_WD  width of the IF->ID payload {pc, inst}
//   BR_BUS_WD        width of the ID->IF redirect bus {br_taken, br_target}
package if_stage_pkg;

    localparam logic [31:0] BOOT_PC_DEFAULT = 32'h1c00_0000;
    localparam int          FS_TO_DS_BUS_WD = 64;
    localparam int          BR_BUS_WD       = 33;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fs_to_ds_bus_t;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } br_bus_t;

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage. Generates the next PC, drives a synchronous
// instruction SRAM (read data valid the cycle after a request), and holds
// the fetched {pc, inst} pair for ID over a valid/allowin handshake.
//
// Ports:
//   clk, resetn            pipeline clock, async active-low reset
//   ds_allowin             ID can accept an instruction this cycle
//   br_taken, br_target    single-cycle redirect from ID
//   fs_to_ds_valid         {fs_pc, fs_inst} valid for ID
//   fs_pc, fs_inst         held instruction address / word
//   inst_sram_*            SRAM request / read data
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] BOOT_PC = BOOT_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ds_allowin,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
    output logic        inst_sram_en,
    output logic        inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata
);

    localparam logic [31:0] RESET_PC = BOOT_PC - 32'd4;

    logic        started;
    logic        fs_valid;
    logic        buf_valid;
    logic [31:0] buf_inst;

    logic [31:0] seq_pc;
    logic [31:0] nextpc;
    logic        fs_allowin;
    logic        stall_capture;

    // Reset value of fs_pc is BOOT_PC-4 so the sequential adder yields
    // BOOT_PC for the very first request without a special case.
    assign seq_pc     = fs_pc + 32'd4;
    assign nextpc     = br_taken ? br_target : seq_pc;
    assign fs_allowin = !fs_valid || ds_allowin || br_taken;

    assign inst_sram_en    = started && fs_allowin;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_we    = 1'b0;
    assign inst_sram_wdata = 32'd0;

    // SRAM output is only guaranteed the cycle after a request, so a
    // stalled instruction is copied aside on its first stall cycle.
    assign stall_capture = fs_valid && !ds_allowin && !br_taken && !buf_valid;

    assign fs_inst        = buf_valid ? buf_inst : inst_sram_rdata;
    assign fs_to_ds_valid = fs_valid && !br_taken;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            started   <= 1'b0;
            fs_valid  <= 1'b0;
            fs_pc     <= RESET_PC;
            buf_valid <= 1'b0;
            buf_inst  <= 32'd0;
        end else begin
            started <= 1'b1;
            if (inst_sram_en) begin
                fs_valid  <= 1'b1;
                fs_pc     <= nextpc;
                buf_valid <= 1'b0;
            end else if (stall_capture) begin
                buf_inst  <= inst_sram_rdata;
                buf_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: synchronous SRAM model with known contents (random
// data on idle cycles), a fetch-level reference model checked every
// negative clock edge, and directed literal checks from the stimulus.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ds_allowin = 1'b1;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'd0;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        inst_sram_en;
    logic        inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata = 32'd0;

    int n_checks = 0;
    int n_fail   = 0;

    if_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .ds_allowin      (ds_allowin),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .fs_to_ds_valid  (fs_to_ds_valid),
        .fs_pc           (fs_pc),
        .fs_inst         (fs_inst),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata)
    );

    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h1c00_0008) return 32'h0280_0421;
        return {a[15:0] ^ 16'h5a5a, a[31:16]};
    endfunction

    // Synchronous SRAM: data for a request appears after the edge; on idle
    // cycles the output is garbage.
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= mem_fn(inst_sram_addr);
        else              inst_sram_rdata <= $urandom;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the fetch stage holds, at the level of
    // "which PC is resident, and is it live". The held word must always
    // be the memory content at that PC.
    logic        m_started, m_valid;
    logic [31:0] m_pc;
    logic        m_en;
    logic [31:0] m_next;

    always_comb begin
        m_next = br_taken ? br_target : m_pc + 32'd4;
        m_en   = m_started && (!m_valid || ds_allowin || br_taken);
    end

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_started <= 1'b0;
            m_valid   <= 1'b0;
            m_pc      <= 32'h1bff_fffc;
        end else begin
            m_started <= 1'b1;
            if (m_en) begin
                m_valid <= 1'b1;
                m_pc    <= m_next;
            end
        end
    end

    always @(negedge clk) begin
        if (resetn) begin
            chk("model_en",    {31'd0, inst_sram_en},   {31'd0, m_en});
            chk("model_addr",  inst_sram_addr,          m_next);
            chk("model_valid", {31'd0, fs_to_ds_valid}, {31'd0, m_valid && !br_taken});
            chk("model_pc",    fs_pc,                   m_pc);
            chk("model_we",    {31'd0, inst_sram_we},   32'd0);
            chk("model_wdata", inst_sram_wdata,         32'd0);
            if (fs_to_ds_valid)
                chk("model_inst", fs_inst, mem_fn(m_pc));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step();
        step();
        chk("rst_valid", {31'd0, fs_to_ds_valid}, 32'd0);
        chk("rst_en",    {31'd0, inst_sram_en},   32'd0);
        chk("rst_addr",  inst_sram_addr,          32'h1c00_0000);
        chk("rst_pc",    fs_pc,                   32'h1bff_fffc);

        @(negedge clk);
        resetn = 1'b1;

        // Startup sequence
        step();
        chk("e0_en",    {31'd0, inst_sram_en},   32'd1);
        chk("e0_addr",  inst_sram_addr,          32'h1c00_0000);
        chk("e0_valid", {31'd0, fs_to_ds_valid}, 32'd0);
        step();
        chk("e1_valid", {31'd0, fs_to_ds_valid}, 32'd1);
        chk("e1_pc",    fs_pc,                   32'h1c00_0000);
        chk("e1_addr",  inst_sram_addr,          32'h1c00_0004);
        step();
        chk("e2_pc",   fs_pc,          32'h1c00_0004);
        chk("e2_addr", inst_sram_addr, 32'h1c00_0008);
        step();
        chk("e3_pc",   fs_pc,   32'h1c00_0008);
        chk("e3_inst", fs_inst, 32'h0280_0421);

        // Three stall cycles; SRAM output goes random after the first
        ds_allowin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_en",   {31'd0, inst_sram_en}, 32'd0);
            chk("stall_inst", fs_inst,               32'h0280_0421);
            chk("stall_pc",   fs_pc,                 32'h1c00_0008);
            if (i < 2) step();
        end
        step();
        ds_allowin = 1'b1;
        #1;
        chk("rel_valid", {31'd0, fs_to_ds_valid}, 32'd1);
        chk("rel_inst",  fs_inst,                 32'h0280_0421);
        chk("rel_addr",  inst_sram_addr,          32'h1c00_000c);
        step();
        chk("rel_pc", fs_pc, 32'h1c00_000c);
        step();
        chk("pre_br_pc", fs_pc, 32'h1c00_0010);

        // Redirect with no stall
        br_taken  = 1'b1;
        br_target = 32'h1c00_0100;
        #1;
        chk("br_valid", {31'd0, fs_to_ds_valid}, 32'd0);
        chk("br_addr",  inst_sram_addr,          32'h1c00_0100);
        step();
        br_taken = 1'b0;
        #1;
        chk("br_pc",    fs_pc,                   32'h1c00_0100);
        chk("br_valid2",{31'd0, fs_to_ds_valid}, 32'd1);

        // Redirect while buffered stall
        ds_allowin = 1'b0;
        step();
        step();
        br_taken  = 1'b1;
        br_target = 32'h1c00_0200;
        #1;
        chk("bbr_valid", {31'd0, fs_to_ds_valid}, 32'd0);
        chk("bbr_en",    {31'd0, inst_sram_en},   32'd1);
        chk("bbr_addr",  inst_sram_addr,          32'h1c00_0200);
        step();
        br_taken   = 1'b0;
        ds_allowin = 1'b1;
        #1;
        chk("bbr_pc",   fs_pc,   32'h1c00_0200);
        chk("bbr_inst", fs_inst, mem_fn(32'h1c00_0200));

        // Misaligned target passes through; then PC wrap-around
        br_taken  = 1'b1;
        br_target = 32'h1c00_0302;
        #1;
        chk("mis_addr", inst_sram_addr, 32'h1c00_0302);
        step();
        br_target = 32'hffff_fffc;
        step();
        br_taken = 1'b0;
        #1;
        chk("wrap_pc",   fs_pc,          32'hffff_fffc);
        chk("wrap_addr", inst_sram_addr, 32'h0000_0000);
        step();
        chk("wrap_pc2", fs_pc, 32'h0000_0000);
        step();

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        chk("arst_valid", {31'd0, fs_to_ds_valid}, 32'd0);
        chk("arst_en",    {31'd0, inst_sram_en},   32'd0);
        chk("arst_pc",    fs_pc,                   32'h1bff_fffc);
        step();
        @(negedge clk);
        resetn = 1'b1;

        // Random traffic checked by the model
        for (int i = 0; i < 60; i++) begin
            step();
            ds_allowin = 1'($urandom_range(0, 3) != 0);
            br_taken   = 1'($urandom_range(0, 7) == 0);
            br_target  = {$urandom} & 32'hffff_fffc;
        end
        step();
        br_taken = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
